// File: rtl/svca_voice_sched_pkg.sv
// Shared types and helpers for the time-multiplexed voice VCA scheduler.
package svca_voice_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Accumulator holds NVOICES signed terms of WIDTH+1 bits without overflow.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned vidx_w);
        return width + vidx_w + 1;
    endfunction

endpackage

// File: rtl/svca_voice_sched_svca.sv
// Combinational VCA: scales an offset-binary sample about midscale by an unsigned CV.
module svca #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] cv,
    output logic [WIDTH-1:0] sig_out
);

    localparam logic [WIDTH:0] MID_X = {2'b01, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0]     s;
    logic signed [2*WIDTH+1:0] s_x;
    logic signed [2*WIDTH+1:0] cv_x;
    logic signed [2*WIDTH+1:0] prod;

    // out = floor((in - mid) * cv / 2**WIDTH) + mid; result always fits WIDTH bits
    always_comb begin
        s       = $signed({1'b0, sig_in}) - $signed(MID_X);
        s_x     = {{(WIDTH+1){s[WIDTH]}}, s};
        cv_x    = {{(WIDTH+2){1'b0}}, cv};
        prod    = s_x * cv_x;
        sig_out = WIDTH'((prod >>> WIDTH) + $signed({{(WIDTH+1){1'b0}}, MID_X}));
    end

endmodule

// File: rtl/svca_voice_sched.sv
// Time-multiplexes one svca across NVOICES voices per sample tick and averages the result.
module svca_voice_sched
    import svca_voice_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NVOICES = 8,
    parameter int unsigned VIDX_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic [NVOICES*WIDTH-1:0]   voice_in,
    input  logic [NVOICES*WIDTH-1:0]   voice_cv,
    input  logic [NVOICES-1:0]         voice_en,
    output logic [WIDTH-1:0]           mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned    ACC_W = acc_width(WIDTH, VIDX_W);
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0] MID_X = {1'b0, MID};

    state_t                   state_q, state_d;
    logic [VIDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]         sh_in_q [NVOICES];
    logic [WIDTH-1:0]         sh_in_d [NVOICES];
    logic [WIDTH-1:0]         sh_cv_q [NVOICES];
    logic [WIDTH-1:0]         sh_cv_d [NVOICES];
    logic [NVOICES-1:0]       sh_en_q, sh_en_d;
    logic [WIDTH-1:0]         mix_out_q, mix_out_d;
    logic                     mix_valid_q, mix_valid_d;
    logic                     overrun_q, overrun_d;

    logic [WIDTH-1:0]         svca_out;
    logic signed [WIDTH:0]    term;

    svca #(.WIDTH(WIDTH)) u_svca (
        .sig_in  (sh_in_q[idx_q]),
        .cv      (sh_cv_q[idx_q]),
        .sig_out (svca_out)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sh_in_d     = sh_in_q;
        sh_cv_d     = sh_cv_q;
        sh_en_d     = sh_en_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = 1'b0;

        term = '0;
        if (sh_en_q[idx_q]) begin
            term = $signed({1'b0, svca_out}) - $signed(MID_X);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    for (int unsigned k = 0; k < NVOICES; k++) begin
                        sh_in_d[k] = voice_in[k*WIDTH +: WIDTH];
                        sh_cv_d[k] = voice_cv[k*WIDTH +: WIDTH];
                    end
                    sh_en_d = voice_en;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                overrun_d = sample_tick;
                acc_d     = acc_q + {{VIDX_W{term[WIDTH]}}, term};
                idx_d     = idx_q + VIDX_W'(1);
                if (idx_q == VIDX_W'(NVOICES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                overrun_d   = sample_tick;
                // Arithmetic shift floors the mean; it always lies within one signed WIDTH range
                mix_out_d   = WIDTH'((acc_q >>> VIDX_W) + $signed({{VIDX_W{1'b0}}, MID_X}));
                mix_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            for (int unsigned k = 0; k < NVOICES; k++) begin
                sh_in_q[k] <= MID;
                sh_cv_q[k] <= '0;
            end
            sh_en_q     <= '0;
            mix_out_q   <= MID;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sh_in_q     <= sh_in_d;
            sh_cv_q     <= sh_cv_d;
            sh_en_q     <= sh_en_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_svca_voice_sched.sv
// Self-checking bench for svca_voice_sched: vector table, corner sequences and a random model check.
module tb_svca_voice_sched;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic [63:0] voice_in;
    logic [63:0] voice_cv;
    logic [7:0]  voice_en;
    logic [7:0]  mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int tests  = 0;
    int failed = 0;

    svca_voice_sched #(.WIDTH(8), .NVOICES(8), .VIDX_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .voice_in    (voice_in),
        .voice_cv    (voice_cv),
        .voice_en    (voice_en),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] vin;
        logic [63:0] cv;
        logic [7:0]  en;
        int          exp_mix;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference: mean of per-voice gains floor((x-128)*cv/256), re-centred at 128
    function automatic int model_mix(input logic [63:0] vin, input logic [63:0] cv, input logic [7:0] en);
        int sum = 0;
        for (int k = 0; k < 8; k++) begin
            if (en[k]) begin
                int x = int'(vin[k*8 +: 8]) - 128;
                int g = int'(cv[k*8 +: 8]);
                sum += floor_div(x * g, 256);
            end
        end
        return floor_div(sum, 8) + 128;
    endfunction

    task automatic run_frame(input string name, input logic [63:0] vin, input logic [63:0] cv,
                             input logic [7:0] en, input int exp_mix, input bit scramble);
        int lat = 0;
        int busy_cnt = 0;
        int ovr = 0;
        @(posedge clk); #1;
        voice_in = vin; voice_cv = cv; voice_en = en; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        if (busy) busy_cnt++;
        while (!mix_valid && lat < 20) begin
            if (scramble) begin
                voice_in = {$urandom, $urandom};
                voice_cv = {$urandom, $urandom};
                voice_en = 8'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (overrun) ovr++;
        end
        check({name, " latency"}, lat, 9);
        check({name, " mix_out"}, int'(mix_out), exp_mix);
        check({name, " busy_cycles"}, busy_cnt, 9);
        check({name, " overrun"}, ovr, 0);
        @(posedge clk); #1;
        check({name, " valid_width"}, int'(mix_valid), 0);
    endtask

    initial begin
        int lat;
        int ovr;
        int pulses;
        logic [63:0] rv, rc;
        logic [7:0]  re;

        vecs[0] = '{"all_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 254};
        vecs[1] = '{"v3_neg",   64'h0,                   64'h0000_0000_FF00_0000, 8'h08, 112};
        vecs[2] = '{"v3_cv0",   64'h0,                   64'h0,                   8'h08, 128};
        vecs[3] = '{"all_min",  64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0};
        vecs[4] = '{"all_off",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 128};
        vecs[5] = '{"half_cv",  64'hFFFF_FFFF_FFFF_FFFF, 64'h8080_8080_8080_8080, 8'hFF, 191};

        rst = 1'b1; sample_tick = 1'b0;
        voice_in = '0; voice_cv = '0; voice_en = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst mix_out", int'(mix_out), 128);
        check("rst mix_valid", int'(mix_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mix_valid || overrun || busy) pulses++;
        end
        check("idle no pulses", pulses, 0);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].name, vecs[i].vin, vecs[i].cv, vecs[i].en, vecs[i].exp_mix, 1'b0);
        end

        // Second tick lands mid-frame, then a tick right on the mix_valid cycle
        @(posedge clk); #1;
        voice_in = '1; voice_cv = '1; voice_en = '1; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        ovr = 0;
        for (int c = 1; c <= 9; c++) begin
            sample_tick = (c == 4);
            @(posedge clk); #1;
            if (overrun) ovr++;
        end
        check("ovr pulses", ovr, 1);
        check("ovr valid", int'(mix_valid), 1);
        check("ovr mix_out", int'(mix_out), 254);
        voice_in = '0; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        lat = 0; ovr = 0;
        while (!mix_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (overrun) ovr++;
        end
        check("b2b latency", lat, 9);
        check("b2b mix_out", int'(mix_out), 0);
        check("b2b overrun", ovr, 0);

        // Inputs change after the tick; the snapshot must be used
        @(posedge clk); #1;
        voice_in = '1; voice_cv = '1; voice_en = '1; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        lat = 0;
        while (!mix_valid && lat < 20) begin
            if (lat == 2) voice_in = '0;
            @(posedge clk); #1;
            lat++;
        end
        check("snap latency", lat, 9);
        check("snap mix_out", int'(mix_out), 254);
        run_frame("snap_next", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);

        // Reset mid-frame aborts it
        @(posedge clk); #1;
        voice_in = '1; voice_cv = '1; voice_en = '1; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst mix_out", int'(mix_out), 128);
        check("midrst valid", int'(mix_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (mix_valid) pulses++;
        end
        check("midrst no valid", pulses, 0);
        check("midrst hold", int'(mix_out), 128);
        run_frame("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 254, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rv = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            re = 8'($urandom);
            if (i % 5 == 0) re = 8'hFF;
            run_frame("rand", rv, rc, re, model_mix(rv, rc, re), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
